// File: rtl/jtag_tap_sequencer.sv
// IEEE 1149.1 TAP controller with IR/DR strobes and a saturating shift counter.
// Optional instruction decode outputs are enabled by defining JTAG_TAP_IR_DECODE_EN.
`timescale 1ns/1ps

module jtag_tap_sequencer #(
    parameter int IR_WIDTH  = 5,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tms,
    input  logic [IR_WIDTH-1:0]  ir_in,
    output logic [3:0]           state,
    output logic                 tap_reset,
    output logic                 capture_ir,
    output logic                 shift_ir,
    output logic                 update_ir,
    output logic                 capture_dr,
    output logic                 shift_dr,
    output logic                 update_dr,
    output logic                 tdo_en,
    output logic [CNT_WIDTH-1:0] shift_cnt
`ifdef JTAG_TAP_IR_DECODE_EN
    ,
    output logic                 sel_idcode,
    output logic                 sel_dtmcs,
    output logic                 sel_dmi,
    output logic                 sel_bypass
`endif
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    tap_state_t           state_r;
    tap_state_t           next_state_s;
    logic [CNT_WIDTH-1:0] shift_cnt_r;

    // TAP state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= TLR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // TAP next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            TLR:      next_state_s = tms ? TLR    : RTI;
            RTI:      next_state_s = tms ? SEL_DR : RTI;
            SEL_DR:   next_state_s = tms ? SEL_IR : CAP_DR;
            CAP_DR:   next_state_s = tms ? EX1_DR : SH_DR;
            SH_DR:    next_state_s = tms ? EX1_DR : SH_DR;
            EX1_DR:   next_state_s = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: next_state_s = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   next_state_s = tms ? UPD_DR : SH_DR;
            UPD_DR:   next_state_s = tms ? SEL_DR : RTI;
            SEL_IR:   next_state_s = tms ? TLR    : CAP_IR;
            CAP_IR:   next_state_s = tms ? EX1_IR : SH_IR;
            SH_IR:    next_state_s = tms ? EX1_IR : SH_IR;
            EX1_IR:   next_state_s = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: next_state_s = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   next_state_s = tms ? UPD_IR : SH_IR;
            UPD_IR:   next_state_s = tms ? SEL_DR : RTI;
            default:  next_state_s = TLR;
        endcase
    end

    // Shift counter: cleared at capture/reset, held through pause so a resumed shift keeps counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                TLR, CAP_IR, CAP_DR: shift_cnt_r <= {CNT_WIDTH{1'b0}};
                SH_IR, SH_DR: begin
                    if (shift_cnt_r != CNT_MAX) begin
                        shift_cnt_r <= shift_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        shift_cnt_r <= shift_cnt_r;
                    end
                end
                default: shift_cnt_r <= shift_cnt_r;
            endcase
        end
    end

    assign state      = state_r;
    assign shift_cnt  = shift_cnt_r;
    assign tap_reset  = (state_r == TLR);
    assign capture_ir = (state_r == CAP_IR);
    assign shift_ir   = (state_r == SH_IR);
    assign update_ir  = (state_r == UPD_IR);
    assign capture_dr = (state_r == CAP_DR);
    assign shift_dr   = (state_r == SH_DR);
    assign update_dr  = (state_r == UPD_DR);
    assign tdo_en     = shift_ir | shift_dr;

`ifdef JTAG_TAP_IR_DECODE_EN
    // Returns {idcode, dtmcs, dmi, bypass}; unknown instructions fall back to bypass
    function automatic logic [3:0] ir_decode(input logic [IR_WIDTH-1:0] ir);
        logic [3:0] sel;
        case (ir)
            IR_WIDTH'(5'h01): sel = 4'b1000;
            IR_WIDTH'(5'h10): sel = 4'b0100;
            IR_WIDTH'(5'h11): sel = 4'b0010;
            default:          sel = 4'b0001;
        endcase
        return sel;
    endfunction

    assign {sel_idcode, sel_dtmcs, sel_dmi, sel_bypass} = ir_decode(ir_in);
`else
    logic ir_in_unused_s;
    assign ir_in_unused_s = ^ir_in;
`endif

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Self-checking bench for jtag_tap_sequencer: table-driven TAP model compared every cycle,
// plus directed scans with hand-computed expectations.
`timescale 1ns/1ps

module tb_jtag_tap_sequencer;

    localparam int IW = 5;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          tms;
    logic [IW-1:0] ir_in;
    logic [3:0]    state;
    logic          tap_reset, capture_ir, shift_ir, update_ir;
    logic          capture_dr, shift_dr, update_dr, tdo_en;
    logic [CW-1:0] shift_cnt;
`ifdef JTAG_TAP_IR_DECODE_EN
    logic          sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;
`endif

    jtag_tap_sequencer #(.IR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .tms(tms), .ir_in(ir_in),
        .state(state), .tap_reset(tap_reset),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdo_en(tdo_en), .shift_cnt(shift_cnt)
`ifdef JTAG_TAP_IR_DECODE_EN
        ,
        .sel_idcode(sel_idcode), .sel_dtmcs(sel_dtmcs),
        .sel_dmi(sel_dmi), .sel_bypass(sel_bypass)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: transition tables indexed by state code, counter as an integer
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];
    logic [3:0] m_state;
    int         m_cnt;

    task automatic arc(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 4'hF;
            m_cnt   <= 0;
        end else begin
            if (m_state == 4'hF || m_state == 4'hE || m_state == 4'h6)
                m_cnt <= 0;
            else if (m_state == 4'hA || m_state == 4'h2)
                m_cnt <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            m_state <= tms ? nxt1[m_state] : nxt0[m_state];
        end
    end

    int n_cap_ir, n_sh_ir, n_upd_ir, n_upd_dr;
    logic [19:0] exp_vec, act_vec;
    logic [6:0]  strobes;

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        exp_vec = {m_state, m_state == 4'hF, m_state == 4'hE, m_state == 4'hA, m_state == 4'hD,
                   m_state == 4'h6, m_state == 4'h2, m_state == 4'h5,
                   (m_state == 4'hA) || (m_state == 4'h2), m_cnt[CW-1:0]};
        act_vec = {state, tap_reset, capture_ir, shift_ir, update_ir,
                   capture_dr, shift_dr, update_dr, tdo_en, shift_cnt};
        chk("cycle_outputs", {12'd0, act_vec}, {12'd0, exp_vec});
        strobes = {tap_reset, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr};
        chk("strobe_onehot", {31'd0, $countones(strobes) <= 1}, 32'd1);
`ifdef JTAG_TAP_IR_DECODE_EN
        chk("ir_decode", {28'd0, sel_idcode, sel_dtmcs, sel_dmi, sel_bypass},
            {28'd0, ir_in == 5'h01, ir_in == 5'h10, ir_in == 5'h11,
             !(ir_in == 5'h01 || ir_in == 5'h10 || ir_in == 5'h11)});
`endif
        if (capture_ir) n_cap_ir++;
        if (shift_ir)   n_sh_ir++;
        if (update_ir)  n_upd_ir++;
        if (update_dr)  n_upd_dr++;
    end

    // Paths from TLR to each state (LSB first) and the code each must reach
    int         plen  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [6:0] pbits [16] = '{7'b0000000, 7'b0000000, 7'b0000010, 7'b0000010,
                               7'b0000010, 7'b0001010, 7'b0001010, 7'b0101010,
                               7'b0011010, 7'b0000110, 7'b0000110, 7'b0000110,
                               7'b0010110, 7'b0010110, 7'b1010110, 7'b0110110};
    logic [3:0] pcode [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                               4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    int         ir_seq [11] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    int         pr_seq [6]  = '{1, 0, 0, 1, 0, 0};

    task automatic tick(input logic t);
        tms = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic goto_state(input int idx);
        do_reset();
        for (int i = 0; i < plen[idx]; i++) begin
            tick(pbits[idx][i]);
        end
    endtask

    task automatic clr_counts();
        n_cap_ir = 0; n_sh_ir = 0; n_upd_ir = 0; n_upd_dr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arc(4'hF, 4'hC, 4'hF); arc(4'hC, 4'hC, 4'h7);
        arc(4'h7, 4'h6, 4'h4); arc(4'h4, 4'hE, 4'hF);
        arc(4'h6, 4'h2, 4'h1); arc(4'h2, 4'h2, 4'h1);
        arc(4'h1, 4'h3, 4'h5); arc(4'h3, 4'h3, 4'h0);
        arc(4'h0, 4'h2, 4'h5); arc(4'h5, 4'hC, 4'h7);
        arc(4'hE, 4'hA, 4'h9); arc(4'hA, 4'hA, 4'h9);
        arc(4'h9, 4'hB, 4'hD); arc(4'hB, 4'hB, 4'h8);
        arc(4'h8, 4'hA, 4'hD); arc(4'hD, 4'hC, 4'h7);
        clr_counts();
        tms = 1'b1;
        ir_in = 5'h00;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {28'd0, state}, 32'hF);
        chk("reset_tap_reset", {31'd0, tap_reset}, 32'd1);
        chk("reset_tdo_en", {31'd0, tdo_en}, 32'd0);
        chk("reset_cnt", {24'd0, shift_cnt}, 32'd0);
        rst = 1'b0;
        tms = 1'b0;

        // First edge after release leaves TLR
        tick(1'b0);
        chk("first_edge_rti", {28'd0, state}, 32'hC);

        // IR scan from RTI
        goto_state(1);
        clr_counts();
        for (int i = 0; i < 11; i++) begin
            tick(ir_seq[i][0]);
            if (i == 8) begin
                chk("ir_ex1_state", {28'd0, state}, 32'h9);
                chk("ir_ex1_cnt", {24'd0, shift_cnt}, 32'd5);
            end
        end
        chk("ir_final_state", {28'd0, state}, 32'hC);
        chk("ir_capture_cycles", n_cap_ir, 32'd1);
        chk("ir_shift_cycles", n_sh_ir, 32'd5);
        chk("ir_update_cycles", n_upd_ir, 32'd1);

        // Pause-resume in DR: two extra shifts, exit shifts the third
        goto_state(4);
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(pr_seq[i][0]);
            if (i == 3) begin
                chk("pr_ex2_state", {28'd0, state}, 32'h0);
                chk("pr_ex2_cnt", {24'd0, shift_cnt}, 32'd3);
            end
            if (i == 4) begin
                chk("pr_resume_state", {28'd0, state}, 32'h2);
                chk("pr_resume_cnt", {24'd0, shift_cnt}, 32'd3);
            end
        end
        chk("pr_final_cnt", {24'd0, shift_cnt}, 32'd4);

        // Asynchronous reset in the middle of a DR shift
        goto_state(4);
        tick(1'b0);
        tick(1'b0);
        clr_counts();
        #2 rst = 1'b1;
        #1;
        chk("midshift_state", {28'd0, state}, 32'hF);
        chk("midshift_tap_reset", {31'd0, tap_reset}, 32'd1);
        chk("midshift_cnt", {24'd0, shift_cnt}, 32'd0);
        chk("midshift_tdo_en", {31'd0, tdo_en}, 32'd0);
        tms = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tms = 1'b0;
        tick(1'b0);
        tick(1'b0);
        chk("midshift_after_state", {28'd0, state}, 32'hC);
        chk("midshift_no_update_dr", n_upd_dr, 32'd0);

        // Five tms=1 edges reach TLR from every state
        for (int s = 0; s < 16; s++) begin
            goto_state(s);
            chk($sformatf("path_%0d", s), {28'd0, state}, {28'd0, pcode[s]});
            repeat (5) tick(1'b1);
            chk($sformatf("force_tlr_%0d", s), {28'd0, state}, 32'hF);
        end

        // Counter saturation
        goto_state(4);
        repeat (300) tick(1'b0);
        chk("sat_cnt", {24'd0, shift_cnt}, 32'd255);
        tick(1'b0);
        chk("sat_hold", {24'd0, shift_cnt}, 32'd255);

`ifdef JTAG_TAP_IR_DECODE_EN
        ir_in = 5'h11;
        #1;
        chk("dec_dmi", {28'd0, sel_idcode, sel_dtmcs, sel_dmi, sel_bypass}, 32'b0010);
        ir_in = 5'h07;
        #1;
        chk("dec_bypass", {28'd0, sel_idcode, sel_dtmcs, sel_dmi, sel_bypass}, 32'b0001);
        for (int v = 0; v < 32; v++) begin
            ir_in = v[IW-1:0];
            tick(1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
